// File: rtl/aw_channel_arbiter_pkg.sv
// Shared write-address interconnect definitions: arbiter state encodings, clog2 helper
// and default sizing constants.
package aw_channel_arbiter_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  localparam int unsigned NumMastersDefault = 2;
  localparam int unsigned OrderDepthDefault = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/aw_channel_arbiter_if.sv
// AW arbiter signal bundle: master request/handshake inputs, grant and write-order outputs.
interface aw_channel_arbiter_if
  import aw_channel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = NumMastersDefault,
  parameter int unsigned MASTER_ID_W = clog2(NumMastersDefault)
);

  logic [NUM_MASTERS-1:0] M_AWVALID;
  logic                   HandShake_Done;
  logic                   W_Order_Pop;
  logic                   Channel_Request;
  logic [NUM_MASTERS-1:0] Grant;
  logic [MASTER_ID_W-1:0] Selected_Master;
  logic                   Arb_Busy;
  logic                   W_Order_Valid;
  logic [MASTER_ID_W-1:0] W_Order_Master;
  logic                   Order_Full;

  modport slave (
    input  M_AWVALID, HandShake_Done, W_Order_Pop,
    output Channel_Request, Grant, Selected_Master, Arb_Busy,
           W_Order_Valid, W_Order_Master, Order_Full
  );

  modport master (
    output M_AWVALID, HandShake_Done, W_Order_Pop,
    input  Channel_Request, Grant, Selected_Master, Arb_Busy,
           W_Order_Valid, W_Order_Master, Order_Full
  );

endinterface

// File: rtl/aw_order_fifo.sv
// Write-order FIFO: records granted AW master indices so W data is routed in AW order.
module aw_order_fifo
  import aw_channel_arbiter_pkg::*;
#(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = OrderDepthDefault
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [Width-1:0] head
);

  localparam int unsigned PtrW = clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Stale storage is masked so the head reads zero whenever nothing is queued.
  assign head    = empty ? '0 : mem_q[rptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wptr_q <= wptr_q + PtrW'(1);
      if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (do_push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/aw_channel_arbiter.sv
// Round-robin AW channel arbiter: arms the handshake checker, holds the grant until it
// completes, and logs each completed grant in the write-order FIFO.
module aw_channel_arbiter
  import aw_channel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = NumMastersDefault,
  parameter int unsigned MASTER_ID_W = clog2(NumMastersDefault),
  parameter int unsigned ORDER_DEPTH = OrderDepthDefault
) (
  input logic                 ACLK,
  input logic                 ARESETN,
  aw_channel_arbiter_if.slave bus
);

  logic [1:0]             state_q, state_d;
  logic [MASTER_ID_W-1:0] sel_q, sel_d;
  logic [MASTER_ID_W-1:0] last_q, last_d;
  logic [MASTER_ID_W-1:0] winner;
  logic                   found;
  logic [NUM_MASTERS-1:0] grant;
  logic                   fifo_full, fifo_empty, fifo_push;
  logic [MASTER_ID_W-1:0] fifo_head;

  // Two passes: masters above the last winner first, then wrap to the bottom.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (!found && bus.M_AWVALID[j] && (MASTER_ID_W'(j) > last_q)) begin
        winner = MASTER_ID_W'(j);
        found  = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      if (!found && bus.M_AWVALID[j]) begin
        winner = MASTER_ID_W'(j);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (found && !fifo_full) begin
          state_d = StReq;
          sel_d   = winner;
        end
      end
      // Done is stale while the checker is being armed, so it is not looked at here.
      StReq: state_d = StWait;
      StWait: begin
        if (bus.HandShake_Done) begin
          state_d = StIdle;
          last_d  = sel_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= StIdle;
      sel_q   <= '0;
      last_q  <= MASTER_ID_W'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    grant = '0;
    if (state_q == StWait) grant[sel_q] = 1'b1;
  end

  assign fifo_push = (state_q == StWait) && bus.HandShake_Done;

  aw_order_fifo #(
    .Width (MASTER_ID_W),
    .Depth (ORDER_DEPTH)
  ) u_order_fifo (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .push      (fifo_push),
    .push_data (sel_q),
    .pop       (bus.W_Order_Pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign bus.Channel_Request = (state_q == StReq);
  assign bus.Grant           = grant;
  assign bus.Selected_Master = sel_q;
  assign bus.Arb_Busy        = (state_q != StIdle);
  assign bus.W_Order_Valid   = !fifo_empty;
  assign bus.W_Order_Master  = fifo_head;
  assign bus.Order_Full      = fifo_full;

endmodule

// File: doc/aw_channel_arbiter.md
Name: aw_channel_arbiter

Overview:
Write-address channel arbiter placed directly upstream of the AW handshake checker in the interconnect. It selects one of NUM_MASTERS requesting masters by round-robin and pulses Channel_Request to arm the checker. It then holds the grant until the checker reports HandShake_Done. Each completed grant is recorded in an order FIFO, which the W-channel mux uses to route write data in AW order.

Parameters:
NUM_MASTERS, 2, number of master AW ports (≥2)
MASTER_ID_W, 1, width of master index = clog2(NUM_MASTERS)
ORDER_DEPTH, 4, entries in write-order FIFO (power of 2, ≥2)

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
M_AWVALID  in  NUM_MASTERS  per-master AWVALID
HandShake_Done  in  1  from AW handshake checker; 1 = last armed handshake complete
W_Order_Pop  in  1  W mux finished a burst (WLAST handshake); pop order FIFO head
Channel_Request  out  1  one-cycle pulse arming the checker for a new grant
Grant  out  NUM_MASTERS  one-hot AW grant; routes AWVALID/AWREADY
Selected_Master  out  MASTER_ID_W  index of granted master
Arb_Busy  out  1  state != IDLE
W_Order_Valid  out  1  order FIFO non-empty
W_Order_Master  out  MASTER_ID_W  FIFO head: master owning current W burst
Order_Full  out  1  order FIFO full

Behaviour:
- Reset (async, ARESETN=0): state=IDLE, Grant=0, Selected_Master=0, Channel_Request=0, Arb_Busy=0, FIFO empty (W_Order_Valid=0, W_Order_Master=0, Order_Full=0), last_grant=NUM_MASTERS-1 so master 0 has top priority. Reset mid-grant drops the grant and discards all FIFO contents.
- States: IDLE, REQ, WAIT.
- IDLE -> REQ: when |M_AWVALID && !Order_Full.
  - Winner = first asserted bit scanning from (last_grant+1) mod NUM_MASTERS upward with wrap.
  - Winner is latched into Selected_Master.
- REQ (exactly 1 cycle):
  - Channel_Request=1, Grant=0.
  - The checker's HandShake_Done is stale in this cycle and is ignored.
  - No AW handshake can occur because Grant is low.
  - Always -> WAIT.
- WAIT:
  - Grant = one-hot(Selected_Master); Channel_Request=0.
  - On HandShake_Done=1: push Selected_Master into the FIFO, set last_grant=Selected_Master, -> IDLE.
  - Grant deasserts in IDLE.
- Latency: AWVALID high at edge k (IDLE) gives Channel_Request at k+1..k+2, then Grant from k+2. With AWREADY=1, the handshake lands at edge k+3, the checker reports Done at k+3, the push happens at k+4 and the FSM is back in IDLE. Minimum 4 cycles per AW.
- Grant is held in WAIT even if M_AWVALID of the winner drops (AXI violation); no timeout.
- Order FIFO:
  - Push only on WAIT exit; pop on W_Order_Pop && W_Order_Valid.
  - Pop when empty is ignored.
  - Simultaneous push and pop: count unchanged, head advances, new entry written.
  - Push never occurs when full: fullness is checked at IDLE, and only one grant can be in flight.
  - Pointers wrap mod ORDER_DEPTH; the count register is clog2(ORDER_DEPTH)+1 bits.
- Order_Full blocks new grants only. It does not abort an in-flight WAIT.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared interconnect package/header holds:
  - the state encodings (IDLE=2'd0, REQ=2'd1, WAIT=2'd2);
  - the clog2 function;
  - the default NUM_MASTERS / ORDER_DEPTH constants.
- One sub-module: aw_order_fifo (synchronous FIFO, MASTER_ID_W wide, ORDER_DEPTH deep, push/pop/full/empty/head). The round-robin priority encoder stays inline.

Test Plan:
1. Reset, then M_AWVALID=2'b01 with a checker model returning Done 1 cycle after Grant -> Channel_Request pulses exactly once (1 cycle); Grant=01 for the WAIT cycles; FIFO head=0, W_Order_Valid=1.
2. M_AWVALID=2'b11 held continuously, Done returned promptly -> grants alternate 0,1,0,1; FIFO receives 0,1,0,1 and Order_Full=1 after 4 grants; no 5th Channel_Request until W_Order_Pop.
3. FIFO full with M_AWVALID=01; assert W_Order_Pop 1 cycle -> head advances, Order_Full=0, new grant starts next cycle; pushed value appears at tail.
4. Simultaneous push and pop (FIFO count=2, Done and W_Order_Pop same edge) -> count stays 2, head advances by one, new tail correct.
5. ARESETN pulled low during WAIT with Grant=10 -> Grant=0, Channel_Request=0, W_Order_Valid=0 immediately (async). After release with M_AWVALID=11, master 0 is granted first.
6. Done held high while in REQ (stale) -> the FSM still enters WAIT and waits for a fresh Done; no push occurs in the REQ cycle.
